// File: rtl/sprite_rom_arbiter.sv
// Arbitrates one synchronous-read sprite ROM among NUM_REQ requesters.
// Each grant issues a registered ROM address and returns a tagged response two cycles later.
module sprite_rom_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_REQ    = 4,
    parameter bit PRIO0      = 1'b1,
    parameter int MAX_WAIT   = 15,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]   RR_RESET  = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic [BURST_W-1:0]             burst_q, burst_d;
    logic [NUM_REQ-1:0]             lock_hold_q, lock_hold_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]          rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]             s1_gnt_q, s1_gnt_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;

    logic                           starve_hit, lock_win, rr_hit, win_valid, lock_sel;
    logic [IDX_W-1:0]               starve_idx, lock_idx, rr_idx, rr_cand, win_idx;
    logic [NUM_REQ-1:0]             gnt_c;

    // Handshake: a requester holds req (and its address) until it sees gnt in the same
    // cycle; that cycle is the transfer, and rsp_valid for it appears two cycles later.
    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k] && (wait_q[k] == WAIT_MAX)) begin
                starve_hit = 1'b1;
                starve_idx = IDX_W'(k);
            end
        end

        lock_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (lock_hold_q[k]) lock_idx = IDX_W'(k);
        end
        lock_win = (|(lock_hold_q & req)) && (burst_q < BURST_MAX);

        // Descending scan so the nearest requester after rr_ptr overwrites the rest.
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req[rr_cand] && !(PRIO0 && (rr_cand == '0))) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end

        win_valid = 1'b1;
        lock_sel  = 1'b0;
        win_idx   = '0;
        if (starve_hit) begin
            win_idx = starve_idx;
        end else if (lock_win) begin
            win_idx  = lock_idx;
            lock_sel = 1'b1;
        end else if (PRIO0 && req[0]) begin
            win_idx = '0;
        end else if (rr_hit) begin
            win_idx = rr_idx;
        end else begin
            win_valid = 1'b0;
        end

        gnt_c = '0;
        if (win_valid && reset_n) gnt_c[win_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = win_valid ? win_idx : rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_c[k] || !req[k]) begin
                wait_d[k] = '0;
            end else if (wait_q[k] == WAIT_MAX) begin
                wait_d[k] = WAIT_MAX;
            end else begin
                wait_d[k] = wait_q[k] + WAIT_W'(1);
            end
        end
        if (!win_valid) begin
            burst_d = '0;
        end else if (lock_sel) begin
            burst_d = burst_q + BURST_W'(1);
        end else begin
            burst_d = BURST_W'(1);
        end
        lock_hold_d = gnt_c & lock;
        rom_addr_d  = win_valid ? req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : rom_addr_q;
        s1_gnt_d    = gnt_c;
        rsp_valid_d = s1_gnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q      <= '0;
            burst_q     <= '0;
            lock_hold_q <= '0;
            rr_ptr_q    <= RR_RESET;
            rom_addr_q  <= '0;
            s1_gnt_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            wait_q      <= wait_d;
            burst_q     <= burst_d;
            lock_hold_q <= lock_hold_d;
            rr_ptr_q    <= rr_ptr_d;
            rom_addr_q  <= rom_addr_d;
            s1_gnt_q    <= s1_gnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign gnt       = gnt_c;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rom_data;
    assign busy      = (|s1_gnt_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with requester-0 priority, one full round-robin.
module tb_sprite_rom_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [79:0] req_addr;
    logic [3:0]  gnt_a, gnt_b, rsp_valid_a, rsp_valid_b;
    logic [19:0] rom_addr_a, rom_addr_b;
    logic [11:0] rom_data_a, rom_data_b, rsp_data_a, rsp_data_b;
    logic        busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    logic [3:0] rr_exp [5];
    int         rr_idx [5];

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.PRIO0(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .lock(lock),
        .gnt(gnt_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a)
    );

    sprite_rom_arbiter #(.PRIO0(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .lock(lock),
        .gnt(gnt_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b)
    );

    function automatic logic [11:0] rom_fn(input logic [19:0] a);
        return (a[11:0] * 12'd7) ^ 12'h5A3;
    endfunction

    // Synchronous-read ROM models, one per instance.
    always @(posedge clk) begin
        rom_data_a <= rom_fn(rom_addr_a);
        rom_data_b <= rom_fn(rom_addr_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        lock    = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_idx = '{0, 1, 2, 3, 0};

        // Reset with every requester asking
        reset_n  = 1'b0;
        req      = 4'b1111;
        lock     = 4'b0000;
        req_addr = '0;
        #3;
        chk("rst_gnt_a", gnt_a, 4'b0000);
        chk("rst_gnt_b", gnt_b, 4'b0000);
        chk("rst_rsp_valid_a", rsp_valid_a, 4'b0000);
        chk("rst_rom_addr_a", rom_addr_a, 20'h0);
        chk("rst_busy_a", busy_a, 1'b0);
        tick();
        tick();
        #2;
        chk("rst_hold_gnt_a", gnt_a, 4'b0000);
        req     = 4'b0000;
        reset_n = 1'b1;

        // Single request from requester 2
        tick();
        req = 4'b0100;
        req_addr[2*20 +: 20] = 20'h00005;
        #2;
        chk("single_gnt_a", gnt_a, 4'b0100);
        chk("single_gnt_b", gnt_b, 4'b0100);
        tick();
        req = 4'b0000;
        #2;
        chk("single_rom_addr", rom_addr_a, 20'h00005);
        chk("single_busy_s1", busy_a, 1'b1);
        chk("single_rsp_early", rsp_valid_a, 4'b0000);
        tick();
        #2;
        chk("single_rsp_valid", rsp_valid_a, 4'b0100);
        chk("single_rsp_data", rsp_data_a, rom_fn(20'h00005));
        tick();
        #2;
        chk("single_rsp_done", rsp_valid_a, 4'b0000);
        chk("single_busy_done", busy_a, 1'b0);

        // Round-robin with all four requesting (instance b)
        do_reset();
        for (int k = 0; k < 4; k++) req_addr[k*20 +: 20] = 20'h00100 + 20'(k);
        for (int c = 0; c < 7; c++) begin
            tick();
            req = (c < 5) ? 4'b1111 : 4'b0000;
            #2;
            chk($sformatf("rr_gnt_%0d", c), gnt_b, (c < 5) ? rr_exp[c] : 4'b0000);
            if (c >= 2) begin
                chk($sformatf("rr_rsp_%0d", c), rsp_valid_b, rr_exp[c-2]);
                chk($sformatf("rr_data_%0d", c), rsp_data_b, rom_fn(20'h00100 + 20'(rr_idx[c-2])));
            end else begin
                chk($sformatf("rr_rsp_idle_%0d", c), rsp_valid_b, 4'b0000);
            end
        end

        // Priority 0 with starvation override (instance a)
        do_reset();
        req_addr[0 +: 20]  = 20'h00010;
        req_addr[20 +: 20] = 20'h0ABCD;
        for (int c = 1; c <= 17; c++) begin
            tick();
            req = 4'b0011;
            #2;
            chk($sformatf("starve_gnt_%0d", c), gnt_a, (c == 16) ? 4'b0010 : 4'b0001);
            if (c == 17) chk("starve_rom_addr", rom_addr_a, 20'h0ABCD);
        end
        tick();
        req = 4'b0000;
        #2;
        chk("starve_rsp_valid", rsp_valid_a, 4'b0010);
        chk("starve_rsp_data", rsp_data_a, rom_fn(20'h0ABCD));

        // Burst lock on requester 3 with requester 1 waiting (instance b)
        do_reset();
        req_addr[3*20 +: 20] = 20'h00033;
        req_addr[1*20 +: 20] = 20'h00011;
        for (int c = 0; c <= 8; c++) begin
            tick();
            req  = (c == 0) ? 4'b1000 : 4'b1010;
            lock = 4'b1000;
            #2;
            chk($sformatf("lock_gnt_%0d", c), gnt_b, (c < 8) ? 4'b1000 : 4'b0010);
        end
        tick();
        req  = 4'b0000;
        lock = 4'b0000;
        #2;
        chk("lock_idle_gnt", gnt_b, 4'b0000);
        chk("lock_rsp_valid", rsp_valid_b, 4'b1000);
        chk("lock_rom_addr", rom_addr_b, 20'h00011);

        // Reset one cycle after a grant discards the in-flight read
        do_reset();
        req_addr[2*20 +: 20] = 20'h00077;
        req_addr[0 +: 20]    = 20'h00099;
        tick();
        req = 4'b0100;
        #2;
        chk("mid_gnt", gnt_b, 4'b0100);
        tick();
        req     = 4'b0000;
        reset_n = 1'b0;
        #2;
        chk("mid_rsp_valid", rsp_valid_b, 4'b0000);
        chk("mid_busy", busy_b, 1'b0);
        chk("mid_rom_addr", rom_addr_b, 20'h0);
        tick();
        #2;
        chk("mid_rsp_t2", rsp_valid_b, 4'b0000);
        reset_n = 1'b1;
        tick();
        req = 4'b0001;
        #2;
        chk("mid_regnt", gnt_b, 4'b0001);
        tick();
        req = 4'b0000;
        #2;
        chk("mid_rsp_wait", rsp_valid_b, 4'b0000);
        chk("mid_busy_s1", busy_b, 1'b1);
        tick();
        #2;
        chk("mid_rsp_valid_new", rsp_valid_b, 4'b0001);
        chk("mid_rsp_data_new", rsp_data_b, rom_fn(20'h00099));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
